// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared constants, types and helpers for the writeback
//               arbiter. These hold the register-address width and the x0
//               index, the writeback source encoding, and a non-x0 predicate.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

  // Register-file addressing
  localparam int          c_REG_ADDR_W = 5;
  localparam logic [4:0]  c_REG_X0     = 5'd0;
  localparam int          c_NUM_REGS   = 32;

  // Source of the write currently held in the output register
  typedef enum logic [0:0] {
    SRC_ALU  = 1'b0,
    SRC_FIFO = 1'b1
  } wb_src_e;

  // x0 is hard-wired zero: writes and scoreboard updates to it are dropped
  function automatic logic reg_is_live(input logic [c_REG_ADDR_W-1:0] addr);
    return (addr != c_REG_X0);
  endfunction

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO that buffers long-latency results
//               ({rd, data}) until the writeback port has a free slot. Full
//               and empty are derived from a registered occupancy count.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous, active-low
//               push       - write push_data (caller guarantees !full)
//               push_data  - entry to store
//               pop        - discard head (caller guarantees !empty)
//               pop_data   - current head entry
//               full/empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int             c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL_CNT = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  logic w_push;
  logic w_pop;

  // Guard against misuse so occupancy can never run out of range
  assign w_push = push && !full;
  assign w_pop  = pop  && !empty;

  assign full     = (r_count == c_FULL_CNT);
  assign empty    = (r_count == '0);
  assign pop_data = r_mem[r_rd_ptr];

  // Storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Owns the register-file write port. Merges single-cycle ALU
//               results with buffered long-latency results, drives one
//               registered write per cycle (ALU has priority), and keeps a
//               busy scoreboard of registers with outstanding long-latency
//               writes.
// Ports       : clk, reset (async active-low)
//               alu_valid/alu_rd/alu_data      - ALU result, no backpressure
//               mc_valid/mc_ready/mc_rd/mc_data - long-latency result stream
//               issue_valid/issue_rd           - long-latency op issued
//               busy[31:0]                     - pending-write scoreboard
//               rd/write_data/wr_en            - registered regfile write
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [c_REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    mc_valid,
  output logic                    mc_ready,
  input  logic [c_REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]         mc_data,
  input  logic                    issue_valid,
  input  logic [c_REG_ADDR_W-1:0] issue_rd,
  output logic [c_NUM_REGS-1:0]   busy,
  output logic [c_REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]         write_data,
  output logic                    wr_en
);

  localparam int c_ENTRY_W = c_REG_ADDR_W + XLEN;

  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_fifo_push;
  logic                    w_fifo_pop;
  logic [c_ENTRY_W-1:0]    w_fifo_head;
  logic [c_REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]         w_head_data;

  logic                    w_alu_win;
  logic                    w_fifo_win;
  logic [c_NUM_REGS-1:0]   w_busy_nxt;

  logic [c_REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]         r_write_data;
  logic                    r_wr_en;
  wb_src_e                 r_src;
  logic [c_NUM_REGS-1:0]   r_busy;

  // --------------------------------------------------------------------------
  // Long-latency result buffer
  // --------------------------------------------------------------------------
  assign mc_ready = !w_fifo_full;

  // Handshakes to x0 complete but leave nothing to write back
  assign w_fifo_push = mc_valid && mc_ready && reg_is_live(mc_rd);

  wb_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_fifo_push),
    .push_data ({mc_rd, mc_data}),
    .pop       (w_fifo_pop),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign w_head_rd   = w_fifo_head[c_ENTRY_W-1:XLEN];
  assign w_head_data = w_fifo_head[XLEN-1:0];

  // --------------------------------------------------------------------------
  // Slot selection: live ALU result first, otherwise drain the FIFO head
  // --------------------------------------------------------------------------
  assign w_alu_win  = alu_valid && reg_is_live(alu_rd);
  assign w_fifo_win = !w_alu_win && !w_fifo_empty;
  assign w_fifo_pop = w_fifo_win;

  // --------------------------------------------------------------------------
  // Output register; rd/write_data hold when the slot is idle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd         <= c_REG_X0;
      r_write_data <= '0;
      r_wr_en      <= 1'b0;
      r_src        <= SRC_ALU;
    end else if (w_alu_win) begin
      r_rd         <= alu_rd;
      r_write_data <= alu_data;
      r_wr_en      <= 1'b1;
      r_src        <= SRC_ALU;
    end else if (w_fifo_win) begin
      r_rd         <= w_head_rd;
      r_write_data <= w_head_data;
      r_wr_en      <= 1'b1;
      r_src        <= SRC_FIFO;
    end else begin
      r_wr_en      <= 1'b0;
    end
  end

  assign rd         = r_rd;
  assign write_data = r_write_data;
  assign wr_en      = r_wr_en;

  // --------------------------------------------------------------------------
  // Scoreboard. Clear happens on the edge the regfile commits a FIFO-sourced
  // write; a fresh issue to the same register on that edge wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en && (r_src == SRC_FIFO)) begin
      w_busy_nxt[r_rd] = 1'b0;
    end
    if (issue_valid && reg_is_live(issue_rd)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

endmodule : wb_arbiter
`default_nettype wire
